// File: rtl/tmds_pkg.sv
// Shared TMDS types, control tokens and helpers for the 3-channel encoder.
package tmds_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] tmds_disp_t;

    localparam tmds_sym_t CTRL_TOKEN_00 = 10'h354;
    localparam tmds_sym_t CTRL_TOKEN_01 = 10'h0AB;
    localparam tmds_sym_t CTRL_TOKEN_10 = 10'h154;
    localparam tmds_sym_t CTRL_TOKEN_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds q_m, stage 2 applies DC balancing with its own disparity counter.
module tmds_channel_enc
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       de_i,
    input  logic [1:0] ctrl_i,
    output tmds_sym_t  sym_o
);

    logic [8:0] qm_d, qm_q;
    logic       de_q;
    logic [1:0] ctrl_q;
    tmds_sym_t  sym_d, sym_q;
    tmds_disp_t cnt_d, cnt_q;
    logic [3:0] n1_data, n1_qm;
    logic       use_xnor;
    tmds_disp_t diff;

    // The XNOR chain equals the XOR prefix parity with every odd bit inverted.
    always_comb begin
        logic par;
        n1_data  = popcount8(data_i);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);
        qm_d     = '0;
        par      = data_i[0];
        qm_d[0]  = data_i[0];
        for (int unsigned i = 1; i < 8; i++) begin
            par     = par ^ data_i[i];
            qm_d[i] = par ^ (use_xnor & i[0]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_comb begin
        n1_qm = popcount8(qm_q[7:0]);
        diff  = tmds_disp_t'({n1_qm, 1'b0}) - 5'sd8;   // n1 - n0
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!de_q) begin
            case (ctrl_q)
                2'b00:   sym_d = CTRL_TOKEN_00;
                2'b01:   sym_d = CTRL_TOKEN_01;
                2'b10:   sym_d = CTRL_TOKEN_10;
                default: sym_d = CTRL_TOKEN_11;
            endcase
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (n1_qm == 4'd4)) begin
            sym_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
            cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (n1_qm > 4'd4)) ||
                     ((cnt_q < 5'sd0) && (n1_qm < 4'd4))) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q - diff + (qm_q[8] ? 5'sd2 : 5'sd0);
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= '0;
            sym_q  <= CTRL_TOKEN_00;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de_i;
            ctrl_q <= ctrl_i;
            sym_q  <= sym_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI TMDS encoder, 2-cycle latency; blue carries hsync/vsync.
// Optional colour-bar test pattern enabled by defining TMDS_TESTPAT_EN.
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned BAR_COUNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       pix_de,
    input  logic       pix_hsync,
    input  logic       pix_vsync,
`ifdef TMDS_TESTPAT_EN
    input  logic       testpat_en,
`endif
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b,
    output logic       tmds_de
);

    if ((H_ACTIVE % BAR_COUNT) != 0) begin : g_bar_count_check
        $error("BAR_COUNT must divide H_ACTIVE");
    end

    logic [7:0] enc_r, enc_g, enc_b;
    logic [1:0] de_pipe_q;

`ifdef TMDS_TESTPAT_EN
    localparam int unsigned PIX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned BAR_W = H_ACTIVE / BAR_COUNT;

    logic [PIX_W-1:0] pix_cnt_d, pix_cnt_q;
    logic [2:0]       bar;

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (!pix_de) begin
            pix_cnt_d = '0;
        end else if (pix_cnt_q != PIX_W'(H_ACTIVE - 1)) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
        bar = 3'(pix_cnt_q / PIX_W'(BAR_W));
        if (testpat_en) begin
            enc_r = {8{bar[2]}};
            enc_g = {8{bar[1]}};
            enc_b = {8{bar[0]}};
        end else begin
            enc_r = pix_r;
            enc_g = pix_g;
            enc_b = pix_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
        end
    end
`else
    always_comb begin
        enc_r = pix_r;
        enc_g = pix_g;
        enc_b = pix_b;
    end
`endif

    tmds_channel_enc u_ch_r (
        .clk   (clk),
        .reset (reset),
        .data_i(enc_r),
        .de_i  (pix_de),
        .ctrl_i(2'b00),
        .sym_o (tmds_r)
    );

    tmds_channel_enc u_ch_g (
        .clk   (clk),
        .reset (reset),
        .data_i(enc_g),
        .de_i  (pix_de),
        .ctrl_i(2'b00),
        .sym_o (tmds_g)
    );

    tmds_channel_enc u_ch_b (
        .clk   (clk),
        .reset (reset),
        .data_i(enc_b),
        .de_i  (pix_de),
        .ctrl_i({pix_vsync, pix_hsync}),
        .sym_o (tmds_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            de_pipe_q <= '0;
        end else begin
            de_pipe_q <= {de_pipe_q[0], pix_de};
        end
    end

    assign tmds_de = de_pipe_q[1];

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Scoreboard bench for tmds_encoder_3ch; covers the colour-bar pattern when TMDS_TESTPAT_EN is defined.
module tb_tmds_encoder_3ch;

    logic       clk;
    logic       reset;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       pix_de, pix_hsync, pix_vsync;
    logic [9:0] tmds_r, tmds_g, tmds_b;
    logic       tmds_de;

    typedef struct {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       de;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          mcnt[3];
    bit          tp_active;
    logic [23:0] tp_rgb;

`ifdef TMDS_TESTPAT_EN
    logic testpat_en;
    tmds_encoder_3ch #(.H_ACTIVE(16), .BAR_COUNT(8)) u_dut (
        .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_de(pix_de), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .testpat_en(testpat_en),
        .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b), .tmds_de(tmds_de)
    );
`else
    tmds_encoder_3ch u_dut (
        .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_de(pix_de), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b), .tmds_de(tmds_de)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_ch(input int ch, input logic [7:0] d, input bit de,
                            input logic [1:0] c, output logic [9:0] sym);
        int         ones, zeros, n1;
        bit         xn;
        logic [8:0] qm;
        if (!de) begin
            case (c)
                2'd0:    sym = 10'h354;
                2'd1:    sym = 10'h0AB;
                2'd2:    sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            mcnt[ch] = 0;
        end else begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !xn;
            ones  = $countones(qm[7:0]);
            zeros = 8 - ones;
            if (mcnt[ch] == 0 || ones == zeros) begin
                sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                mcnt[ch] += qm[8] ? (ones - zeros) : (zeros - ones);
            end else if ((mcnt[ch] > 0 && ones > zeros) || (mcnt[ch] < 0 && zeros > ones)) begin
                sym = {1'b1, qm[8], ~qm[7:0]};
                mcnt[ch] += (qm[8] ? 2 : 0) + zeros - ones;
            end else begin
                sym = {1'b0, qm[8], qm[7:0]};
                mcnt[ch] += ones - zeros - (qm[8] ? 0 : 2);
            end
        end
    endtask

    task automatic drive(input bit rst, input bit de, input bit hs, input bit vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t        e;
        exp_t        tok;
        logic [23:0] m;
        tok   = '{r: 10'h354, g: 10'h354, b: 10'h354, de: 1'b0};
        reset = rst; pix_de = de; pix_hsync = hs; pix_vsync = vs;
        pix_r = r; pix_g = g; pix_b = b;
        if (rst) begin
            foreach (sb[i]) sb[i] = tok;
            mcnt = '{0, 0, 0};
            e = tok;
        end else begin
            m = tp_active ? tp_rgb : {r, g, b};
            model_ch(0, m[23:16], de, 2'b00, e.r);
            model_ch(1, m[15:8], de, 2'b00, e.g);
            model_ch(2, m[7:0], de, {vs, hs}, e.b);
            e.de = de;
        end
        sb.push_back(e);
    endtask

    task automatic next_sample(output bit got, output exp_t e);
        @(negedge clk);
        got = (sb.size() >= 2);
        if (got) e = sb.pop_front();
    endtask

    task automatic test_reset();
        bit got; exp_t e;
        for (int s = 0; s < 8; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL reset s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            drive(s < 3, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_ctrl();
        bit got; exp_t e; bit hs, vs;
        for (int s = 0; s < 11; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL ctrl s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            if (s == 4 || s == 7 || s == 10) begin
                checks++;
                if (tmds_b !== (s == 4 ? 10'h0AB : s == 7 ? 10'h154 : 10'h2AB) ||
                    tmds_r !== 10'h354 || tmds_g !== 10'h354) begin
                    errors++;
                    $display("FAIL ctrl_token s=%0d: got r=%h g=%h b=%h", s, tmds_r, tmds_g, tmds_b);
                end
            end
            hs = (s < 3) || (s >= 6 && s < 9);
            vs = (s >= 3 && s < 9);
            drive(1'b0, 1'b0, hs, vs, 8'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_data_b(input string name, input bit rst_first);
        bit got; exp_t e;
        logic [9:0]        exp_sym [3] = '{10'h100, 10'h3FF, 10'h100};
        logic signed [4:0] exp_cnt [3] = '{-5'sd8, 5'sd2, -5'sd6};
        for (int s = 0; s < 8; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL %s s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             name, s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            if (rst_first && s < 2) begin
                checks++;
                if (tmds_r !== 10'h354 || tmds_g !== 10'h354 || tmds_b !== 10'h354 || tmds_de !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_post_reset s=%0d: got r=%h g=%h b=%h de=%b, expected 354 x3 de=0",
                             name, s, tmds_r, tmds_g, tmds_b, tmds_de);
                end
            end
            if (s >= 3 && s <= 5) begin
                checks++;
                if (tmds_b !== exp_sym[s-3] || u_dut.u_ch_b.cnt_q !== exp_cnt[s-3] || tmds_de !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_seq s=%0d: got b=%h cnt=%0d de=%b, expected b=%h cnt=%0d de=1",
                             name, s, tmds_b, u_dut.u_ch_b.cnt_q, tmds_de, exp_sym[s-3], exp_cnt[s-3]);
                end
            end
            drive(1'b0, (s >= 1 && s <= 3), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'h00);
        end
    endtask

    task automatic test_data_r();
        bit got; exp_t e;
        for (int s = 0; s < 6; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL data_r s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            if (s == 3 || s == 4) begin
                checks++;
                if (tmds_r !== (s == 3 ? 10'h200 : 10'h354) ||
                    u_dut.u_ch_r.cnt_q !== (s == 3 ? -5'sd8 : 5'sd0)) begin
                    errors++;
                    $display("FAIL data_r_const s=%0d: got r=%h cnt=%0d, expected r=%h cnt=%0d",
                             s, tmds_r, u_dut.u_ch_r.cnt_q, (s == 3 ? 10'h200 : 10'h354), (s == 3 ? -8 : 0));
                end
            end
            drive(1'b0, s == 1, 1'b0, 1'b0, 8'hFF, 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset_midline();
        bit got; exp_t e;
        for (int s = 0; s < 5; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL reset_mid s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            drive(s == 4, s >= 1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        test_data_b("reset_repeat", 1'b1);
    endtask

    task automatic test_back_to_back();
        bit got; exp_t e; bit de, hs, vs;
        logic [7:0] px [3];
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        for (int s = 0; s < 400; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL back_to_back s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            if ($urandom_range(0, 9) == 0) de = ~de;
            if ($urandom_range(0, 5) == 0) hs = ~hs;
            if ($urandom_range(0, 7) == 0) vs = ~vs;
            foreach (px[i]) begin
                case ($urandom_range(0, 3))
                    0:       px[i] = 8'h00;
                    1:       px[i] = 8'hFF;
                    default: px[i] = 8'($urandom);
                endcase
            end
            drive(1'b0, (s < 396) ? de : 1'b0, hs, vs, px[0], px[1], px[2]);
        end
    endtask

`ifdef TMDS_TESTPAT_EN
    task automatic test_testpat();
        bit got; exp_t e; int k; logic [2:0] kb;
        testpat_en = 1'b1;
        for (int s = 0; s < 22; s++) begin
            next_sample(got, e);
            if (got) begin
                checks++;
                if ({tmds_r, tmds_g, tmds_b, tmds_de} !== {e.r, e.g, e.b, e.de}) begin
                    errors++;
                    $display("FAIL testpat s=%0d: got r=%h g=%h b=%h de=%b, expected r=%h g=%h b=%h de=%b",
                             s, tmds_r, tmds_g, tmds_b, tmds_de, e.r, e.g, e.b, e.de);
                end
            end
            k  = (s >= 2) ? (s - 2) / 2 : 0;
            kb = 3'(k);
            tp_active = 1'b1;
            tp_rgb    = {{8{kb[2]}}, {8{kb[1]}}, {8{kb[0]}}};
            drive(1'b0, (s >= 2 && s < 18), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        tp_active  = 1'b0;
        testpat_en = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; pix_de = 1'b0; pix_hsync = 1'b0; pix_vsync = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;
        tp_active = 1'b0; tp_rgb = '0;
        mcnt = '{0, 0, 0};
`ifdef TMDS_TESTPAT_EN
        testpat_en = 1'b0;
`endif
        test_reset();
        test_ctrl();
        test_data_b("data_b", 1'b0);
        test_data_r();
        test_reset_midline();
        test_back_to_back();
`ifdef TMDS_TESTPAT_EN
        test_testpat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
